pool1_ctrl: RTL and testbench



---
 rtl/pool1_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pool1_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pool1_ctrl.sv
// 2x2/stride-2 pooling of the 28x28 f2 map into the 14x14 f3 map; first write 5+RD_LAT cycles after RUN entry.
// Default build is max pooling; defining POOL1_AVG_EN selects average pooling with identical timing.
module pool1_ctrl #(
  parameter int DW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pool1_start,
  output logic [9:0]    f2_raddr,
  input  logic [DW-1:0] f2_rdata,
  output logic [7:0]    f3_waddr,
  output logic [DW-1:0] f3_wdata,
  output logic          f3_wr_en,
  output logic          pool1_busy,
  output logic          pool1_done
);

`ifdef POOL1_AVG_EN
  localparam int AW = DW + 2;
`else
  localparam int AW = DW;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t state_q, state_d;

  logic       cnt0_q, cnt0_d;
  logic       cnt1_q, cnt1_d;
  logic [3:0] cnt2_q, cnt2_d;
  logic [3:0] cnt3_q, cnt3_d;

  logic       issue;
  logic       last_elem;
  logic [9:0] raddr_d, raddr_q;
  logic [9:0] row10;
  logic [7:0] waddr_d;
  logic [7:0] row8;

  assign issue     = (state_q == S_RUN);
  assign last_elem = cnt0_q & cnt1_q & (cnt2_q == 4'd13) & (cnt3_q == 4'd13);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pool1_start) state_d = S_RUN;
      S_RUN:   if (last_elem) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Odometer: column-in-window fastest, output row slowest.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    cnt3_d = cnt3_q;
    if (issue) begin
      cnt0_d = ~cnt0_q;
      if (cnt0_q) begin
        cnt1_d = ~cnt1_q;
        if (cnt1_q) begin
          cnt2_d = (cnt2_q == 4'd13) ? 4'd0 : cnt2_q + 4'd1;
          if (cnt2_q == 4'd13) begin
            cnt3_d = (cnt3_q == 4'd13) ? 4'd0 : cnt3_q + 4'd1;
          end
        end
      end
    end
  end

  // row*28 = row*16 + row*8 + row*4 ; cnt3*14 = cnt3*8 + cnt3*4 + cnt3*2
  assign row10   = {5'd0, cnt3_q, cnt1_q};
  assign raddr_d = (row10 << 4) + (row10 << 3) + (row10 << 2) + {5'd0, cnt2_q, cnt0_q};
  assign row8    = {4'd0, cnt3_q};
  assign waddr_d = (row8 << 3) + (row8 << 2) + (row8 << 1) + {4'd0, cnt2_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt0_q  <= 1'b0;
      cnt1_q  <= 1'b0;
      cnt2_q  <= 4'd0;
      cnt3_q  <= 4'd0;
      raddr_q <= 10'd0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      cnt3_q  <= cnt3_d;
      if (issue) raddr_q <= raddr_d;
    end
  end

  assign f2_raddr = raddr_q;

  // Element tags ride alongside the read: one stage for the address register plus RD_LAT.
  logic [RD_LAT:0]      vld_pipe_q;
  logic [RD_LAT:0]      first_pipe_q;
  logic [RD_LAT:0]      last_pipe_q;
  logic [RD_LAT:0][7:0] waddr_pipe_q;
  logic [RD_LAT+1:0]    done_pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      last_pipe_q  <= '0;
      waddr_pipe_q <= '0;
      done_pipe_q  <= '0;
    end else begin
      vld_pipe_q   <= {vld_pipe_q[RD_LAT-1:0], issue};
      first_pipe_q <= {first_pipe_q[RD_LAT-1:0], ~cnt0_q & ~cnt1_q};
      last_pipe_q  <= {last_pipe_q[RD_LAT-1:0], cnt0_q & cnt1_q};
      waddr_pipe_q <= {waddr_pipe_q[RD_LAT-1:0], waddr_d};
      done_pipe_q  <= {done_pipe_q[RD_LAT:0], state_q == S_DONE};
    end
  end

  logic                 al_vld, al_first, al_last;
  logic [7:0]           al_waddr;
  logic signed [AW-1:0] rdata_x;
  logic signed [AW-1:0] acc_q, acc_nxt;
  logic [DW-1:0]        result;

  assign al_vld   = vld_pipe_q[RD_LAT];
  assign al_first = first_pipe_q[RD_LAT];
  assign al_last  = last_pipe_q[RD_LAT];
  assign al_waddr = waddr_pipe_q[RD_LAT];
  assign rdata_x  = AW'($signed(f2_rdata));

`ifdef POOL1_AVG_EN
  always_comb begin
    acc_nxt = al_first ? rdata_x : acc_q + rdata_x;
    result  = acc_nxt[AW-1:2];
  end
`else
  // Strict greater-than so ties keep the accumulator.
  always_comb begin
    acc_nxt = al_first ? rdata_x : ((rdata_x > acc_q) ? rdata_x : acc_q);
    result  = acc_nxt;
  end
`endif

  logic          wr_en_q;
  logic [DW-1:0] wdata_q;
  logic [7:0]    waddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      wr_en_q <= 1'b0;
      wdata_q <= '0;
      waddr_q <= 8'd0;
    end else begin
      if (al_vld) acc_q <= acc_nxt;
      wr_en_q <= al_vld & al_last;
      if (al_vld & al_last) begin
        wdata_q <= result;
        waddr_q <= al_waddr;
      end
    end
  end

  assign f3_wr_en   = wr_en_q;
  assign f3_wdata   = wdata_q;
  assign f3_waddr   = waddr_q;
  assign pool1_done = done_pipe_q[RD_LAT+1];
  assign pool1_busy = (state_q != S_IDLE) | (|done_pipe_q);

endmodule

// File: tb/tb_pool1_ctrl.sv
// Directed bench for pool1_ctrl: ramp, signed windows, saturated data, back-to-back and mid-run reset.
module tb_pool1_ctrl;
  localparam int DW     = 16;
  localparam int RD_LAT = 2;

  logic          clk;
  logic          rst_n;
  logic          pool1_start;
  logic [9:0]    f2_raddr;
  logic [DW-1:0] f2_rdata;
  logic [7:0]    f3_waddr;
  logic [DW-1:0] f3_wdata;
  logic          f3_wr_en;
  logic          pool1_busy;
  logic          pool1_done;

  pool1_ctrl #(.DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .pool1_start(pool1_start),
    .f2_raddr(f2_raddr), .f2_rdata(f2_rdata),
    .f3_waddr(f3_waddr), .f3_wdata(f3_wdata), .f3_wr_en(f3_wr_en),
    .pool1_busy(pool1_busy), .pool1_done(pool1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // f2 memory with RD_LAT cycles of read latency
  logic [DW-1:0] f2_mem  [0:1023];
  logic [DW-1:0] rd_pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    rd_pipe[0] <= f2_mem[f2_raddr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign f2_rdata = rd_pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  int f3_exp [0:255];
  logic signed [DW-1:0] got [0:255];
  int n_wr, n_done, gap_err, order_err, data_err, exp_addr;
  int t0, first_wr, last_wr, done_cyc, done_cyc_last;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (pool1_busy && !busy_prev) t0 = cyc;
    busy_prev = pool1_busy;
    if (f3_wr_en) begin
      if (n_wr == 0) first_wr = cyc;
      else if (f3_waddr != 8'd0 && (cyc - last_wr) != 4) gap_err++;
      if (int'(f3_waddr) != exp_addr) order_err++;
      if (int'($signed(f3_wdata)) != f3_exp[f3_waddr]) data_err++;
      got[f3_waddr] = f3_wdata;
      exp_addr = (f3_waddr == 8'd195) ? 0 : int'(f3_waddr) + 1;
      last_wr = cyc;
      n_wr++;
    end
    if (pool1_done) begin
      if (n_done == 0) done_cyc = cyc;
      done_cyc_last = cyc;
      n_done++;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_wr = 0; n_done = 0; gap_err = 0; order_err = 0; data_err = 0; exp_addr = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) pool1_start = 1'b1;
    @(negedge clk) pool1_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (n_done < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", longint'(n_done >= n), 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic load_ramp();
    for (int a = 0; a < 1024; a++) f2_mem[a] = DW'(a);
    for (int i = 0; i < 256; i++) begin
`ifdef POOL1_AVG_EN
      f3_exp[i] = 56 * (i / 14) + 2 * (i % 14) + 14;
`else
      f3_exp[i] = 56 * (i / 14) + 2 * (i % 14) + 29;
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pool1_start = 1'b0;
    clear_stats();
    load_ramp();
    repeat (3) @(negedge clk);
    chk("rst_raddr", f2_raddr, 0);
    chk("rst_waddr", f3_waddr, 0);
    chk("rst_wdata", f3_wdata, 0);
    chk("rst_wr_en", f3_wr_en, 0);
    chk("rst_busy", pool1_busy, 0);
    chk("rst_done", pool1_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp run
    clear_stats();
    pulse_start();
    wait_done(1, 2000);
    chk("ramp_writes", n_wr, 196);
    chk("ramp_first_wr", first_wr - t0, RD_LAT + 5);
    chk("ramp_last_wr", last_wr - t0, RD_LAT + 785);
    chk("ramp_done_after_last", done_cyc - last_wr, 1);
    chk("ramp_done_count", n_done, 1);
    chk("ramp_gap_err", gap_err, 0);
    chk("ramp_order_err", order_err, 0);
    chk("ramp_data_err", data_err, 0);
`ifdef POOL1_AVG_EN
    chk("ramp_f3_0", got[0], 14);
    chk("ramp_f3_1", got[1], 16);
    chk("ramp_f3_14", got[14], 70);
    chk("ramp_f3_195", got[195], 768);
`else
    chk("ramp_f3_0", got[0], 29);
    chk("ramp_f3_1", got[1], 31);
    chk("ramp_f3_14", got[14], 85);
    chk("ramp_f3_195", got[195], 783);
`endif
    chk("ramp_busy_after", pool1_busy, 0);

    // Signed windows in the first four output columns, zeros elsewhere
    for (int a = 0; a < 1024; a++) f2_mem[a] = '0;
    for (int i = 0; i < 256; i++) f3_exp[i] = 0;
    f2_mem[0] = -16'sd5;  f2_mem[1] = -16'sd3;  f2_mem[28] = -16'sd8;  f2_mem[29] = -16'sd4;
    f2_mem[2] = 16'sd1;   f2_mem[3] = 16'sd2;   f2_mem[30] = 16'sd3;   f2_mem[31] = 16'sd5;
    f2_mem[4] = -16'sd1;  f2_mem[5] = -16'sd1;  f2_mem[32] = -16'sd1;  f2_mem[33] = -16'sd2;
    f2_mem[6] = 16'sd32767; f2_mem[7] = 16'sd32767; f2_mem[34] = 16'sd32767; f2_mem[35] = 16'sd32767;
`ifdef POOL1_AVG_EN
    f3_exp[0] = -5; f3_exp[1] = 2; f3_exp[2] = -2; f3_exp[3] = 32767;
`else
    f3_exp[0] = -3; f3_exp[1] = 5; f3_exp[2] = -1; f3_exp[3] = 32767;
`endif
    clear_stats();
    pulse_start();
    wait_done(1, 2000);
    chk("sgn_writes", n_wr, 196);
    chk("sgn_data_err", data_err, 0);
`ifdef POOL1_AVG_EN
    chk("sgn_w0", got[0], -5);
    chk("sgn_w1", got[1], 2);
    chk("sgn_w2", got[2], -2);
`else
    chk("sgn_w0", got[0], -3);
    chk("sgn_w1", got[1], 5);
    chk("sgn_w2", got[2], -1);
`endif
    chk("sgn_w3", got[3], 32767);

    // Most negative value everywhere
    for (int a = 0; a < 1024; a++) f2_mem[a] = 16'h8000;
    for (int i = 0; i < 256; i++) f3_exp[i] = -32768;
    clear_stats();
    pulse_start();
    wait_done(1, 2000);
    chk("neg_writes", n_wr, 196);
    chk("neg_data_err", data_err, 0);
    chk("neg_f3_100", got[100], -32768);

    // Start held high: exactly two back-to-back runs before it drops
    load_ramp();
    clear_stats();
    @(negedge clk) pool1_start = 1'b1;
    begin
      int k;
      k = 0;
      while (n_wr < 197 && k < 3000) begin
        @(negedge clk);
        k++;
      end
    end
    pool1_start = 1'b0;
    wait_done(2, 3000);
    repeat (800) @(negedge clk);
    chk("b2b_writes", n_wr, 392);
    chk("b2b_done_count", n_done, 2);
    chk("b2b_done_spacing", done_cyc_last - done_cyc, 786);
    chk("b2b_order_err", order_err, 0);
    chk("b2b_data_err", data_err, 0);
    chk("b2b_gap_err", gap_err, 0);

    // Reset at t0+300, then a clean restart
    clear_stats();
    pulse_start();
    begin
      int k;
      k = 0;
      while ((cyc - t0) < 300 && k < 2000) begin
        @(negedge clk);
        k++;
      end
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", f3_wr_en, 0);
    chk("rst_mid_done", pool1_done, 0);
    chk("rst_mid_busy", pool1_busy, 0);
    @(negedge clk) rst_n = 1'b1;
    clear_stats();
    repeat (900) @(negedge clk);
    chk("rst_no_writes", n_wr, 0);
    chk("rst_no_done", n_done, 0);
    clear_stats();
    pulse_start();
    wait_done(1, 2000);
    chk("restart_writes", n_wr, 196);
    chk("restart_data_err", data_err, 0);
    chk("restart_order_err", order_err, 0);
    chk("restart_done_count", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
